gray_up_down_counter: RTL and testbench
=======================================

# gray_up_down_counter

Registered, parameterized Gray-code up/down counter that directly feeds the gray_to_binary converter stage. It produces a Gray-coded count that changes exactly one bit per step, with synchronous clear, parallel load of a Gray value, wrap or saturate mode, and terminal-count flags. The 4-bit default width matches the converter's `in_gray` input one-to-one.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2..16.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: asynchronous, active-low reset.
  - Asserts immediately on the falling edge of `rst_n`.
  - Deassertion is sampled on `clk`.
- `in_clear`  input  1: synchronous clear to count 0.
- `in_load`  input  1: synchronous load of `in_load_gray`.
- `in_load_gray`  input  WIDTH: Gray-coded load value; every WIDTH-bit pattern is legal.
- `in_en`  input  1: count enable.
- `in_up`  input  1: direction; 1 = increment, 0 = decrement.
- `in_sat`  input  1: 1 = saturate at the end points, 0 = wrap around.
- `out_gray`  output  WIDTH: registered Gray count. Connects to the converter's `in_gray`.
- `out_wrap`  output  1: one-cycle registered pulse on a wrap-around step.
- `out_at_max`  output  1: high when the count is binary 2^WIDTH-1 (Gray `1` followed by zeros).
- `out_at_min`  output  1: high when the count is 0.

## Operation
- **State registers**
  - `bin_q` (WIDTH): binary count.
  - `gray_q` (WIDTH): registered Gray value; always equals `bin_q ^ (bin_q >> 1)`.
  - `wrap_q` (1): wrap pulse register.
- **Priority each cycle:** `in_clear` > `in_load` > `in_en`. With none asserted, all state holds.
- **Clear**
  - `bin_q` = 0, `gray_q` = 0.
  - `wrap_q` = 0.
- **Load**
  - `bin_q` = Gray-to-binary of `in_load_gray`: MSB passes through; each lower bit = XOR of its Gray bit with the next-higher binary bit.
  - `gray_q` = `in_load_gray`.
  - `wrap_q` = 0.
- **Count (`in_en`=1)**
  - Up: `bin_q` + 1, modulo 2^WIDTH. Down: `bin_q` - 1, modulo 2^WIDTH.
  - `gray_q` is recomputed from the next `bin_q`.
- **End points**
  - Up at max with `in_sat`=0: wraps to 0 and sets `wrap_q`=1 for one cycle.
  - Up at max with `in_sat`=1: holds, no wrap pulse.
  - Down at 0 with `in_sat`=0: wraps to max and sets `wrap_q`=1.
  - Down at 0 with `in_sat`=1: holds, no wrap pulse.
- `wrap_q` is 0 in every cycle not described above.
- **Flags:** `out_at_max` and `out_at_min` are decoded combinationally from `bin_q`. They carry no extra latency relative to `out_gray`.
- **Gray property:** consecutive `out_gray` values from count steps differ in exactly one bit, including across a wrap. Clear and load are exempt.

## Timing
- **Reset values**
  - `out_gray` = 0, `out_wrap` = 0.
  - `out_at_min` = 1, `out_at_max` = 0.
- **Latency:** one cycle. Controls sampled at edge N appear on `out_gray`, `out_wrap` and the flags after edge N.
- **Wrap pulse:** `out_wrap` is high in the same cycle as the wrapped `out_gray` value.
- **Simultaneous controls**
  - `in_clear` with `in_load`: result is 0.
  - `in_load` with `in_en`: the loaded value wins; no count step that cycle.
- **Direction change:** `in_up` may toggle every cycle; each enabled cycle moves exactly one step.
- **Reset mid-count:** all outputs return to reset values immediately, independent of `clk`. The count resumes from 0 after `rst_n` rises.
- **Downstream path:** the Gray-to-binary converter adds only combinational delay. The count register must meet timing through that path at the target clock.

## Test plan
- **Reset, then up-count:** `rst_n` low, then high; `in_en`=1, `in_up`=1, `in_sat`=0 for 17 cycles.
  - Required `out_gray` sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - `out_wrap`=1 only on the final 0000.
  - `out_at_max`=1 only on 1000.
- **Down wrap:** from 0, `in_up`=0, `in_en`=1 → `out_gray`=1000 and `out_wrap`=1 for one cycle. Next step → 1001.
- **Saturate:**
  - `in_sat`=1 at 1000 with up-count for 3 cycles → stays 1000, `out_wrap`=0.
  - `in_sat`=1 at 0000 with down-count → stays 0000.
- **Load and priority**
  - Load `in_load_gray`=1101 with `in_en`=1 → `out_gray`=1101.
  - Next up step → 1111.
  - `in_clear`=1 with `in_load`=1 → 0000.
- **Async reset mid-count:** drop `rst_n` at count 0110 between edges → outputs are 0000 / 0 / min=1 / max=0 before the next edge.
- **Random single-bit check:** 10,000 cycles of random `in_en`, `in_up`, `in_sat`.
  - Every count step changes exactly one bit of `out_gray`.
  - Converter output equals a reference binary model.

Source files
------------

// File: rtl/gray_up_down_counter.sv
// Gray-code up/down counter with clear, Gray load, wrap/saturate modes and end-point flags.
// Holds a binary count alongside its registered Gray image so out_gray leaves a flop.
module gray_up_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_clear,
    input  logic             in_load,
    input  logic [WIDTH-1:0] in_load_gray,
    input  logic             in_en,
    input  logic             in_up,
    input  logic             in_sat,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_wrap,
    output logic             out_at_max,
    output logic             out_at_min
);

    localparam logic [WIDTH-1:0] MAX_BIN = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;

    // Gray-to-binary of the load value: running XOR from the MSB down
    always_comb begin
        logic acc;
        load_bin = '0;
        acc      = in_load_gray[WIDTH-1];
        load_bin[WIDTH-1] = acc;
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            acc         = acc ^ in_load_gray[i];
            load_bin[i] = acc;
        end
    end

    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        wrap_d = 1'b0;
        if (in_clear) begin
            bin_d  = '0;
            gray_d = '0;
        end else if (in_load) begin
            bin_d  = load_bin;
            gray_d = in_load_gray;
        end else if (in_en) begin
            if (in_up) begin
                if (bin_q == MAX_BIN) begin
                    if (!in_sat) begin
                        bin_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == '0) begin
                    if (!in_sat) begin
                        bin_d  = MAX_BIN;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
            gray_d = bin_d ^ (bin_d >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign out_gray   = gray_q;
    assign out_wrap   = wrap_q;
    // Flags decode the live count so they line up with out_gray
    assign out_at_max = (bin_q == MAX_BIN);
    assign out_at_min = (bin_q == '0);

endmodule

// File: tb/tb_gray_up_down_counter.sv
// Scoreboard bench for gray_up_down_counter: a binary reference model queues expected
// outputs per driven cycle; each scenario task pops and compares after the clock edge.
module tb_gray_up_down_counter;

    localparam int unsigned W = 4;
    localparam logic [W-1:0] MAXV = 4'b1111;

    typedef struct packed {
        logic [W-1:0] gray;
        logic         wrap;
        logic         at_max;
        logic         at_min;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_clear = 1'b0, in_load = 1'b0, in_en = 1'b0, in_up = 1'b0, in_sat = 1'b0;
    logic [W-1:0] in_load_gray = '0;
    logic [W-1:0] out_gray;
    logic         out_wrap, out_at_max, out_at_min;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t e, o;
    logic [W-1:0] mbin = '0;
    logic         stepped = 1'b0;

    gray_up_down_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_clear(in_clear), .in_load(in_load),
        .in_load_gray(in_load_gray), .in_en(in_en), .in_up(in_up), .in_sat(in_sat),
        .out_gray(out_gray), .out_wrap(out_wrap), .out_at_max(out_at_max), .out_at_min(out_at_min)
    );

    always #5 clk = ~clk;

    // Prefix-XOR form: binary bit i is the parity of Gray bits i and above
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < int'(W); i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic exp_t observe();
        exp_t r;
        r.gray = out_gray; r.wrap = out_wrap; r.at_max = out_at_max; r.at_min = out_at_min;
        return r;
    endfunction

    // Drive one cycle of controls, advance the model, queue its expectation, then pass the edge
    task automatic drive(input logic c, input logic l, input logic [W-1:0] lg,
                         input logic en, input logic up, input logic sat);
        logic w;
        logic [W-1:0] prev;
        in_clear = c; in_load = l; in_load_gray = lg; in_en = en; in_up = up; in_sat = sat;
        w = 1'b0;
        prev = mbin;
        if (c) mbin = '0;
        else if (l) mbin = g2b(lg);
        else if (en) begin
            if (up) begin
                if (mbin == MAXV) begin
                    if (!sat) begin mbin = '0; w = 1'b1; end
                end else mbin = mbin + 4'd1;
            end else begin
                if (mbin == '0) begin
                    if (!sat) begin mbin = MAXV; w = 1'b1; end
                end else mbin = mbin - 4'd1;
            end
        end
        stepped = !c && !l && en && (mbin != prev);
        sb.push_back('{gray: mbin ^ (mbin >> 1), wrap: w, at_max: (mbin == MAXV), at_min: (mbin == '0)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        o = observe();
        n_checks++;
        if (o !== exp_t'({4'b0000, 1'b0, 1'b0, 1'b1})) begin
            n_fail++;
            $display("FAIL reset_values: got gray=%b wrap=%b max=%b min=%b, want 0000/0/0/1",
                     o.gray, o.wrap, o.at_max, o.at_min);
        end
        rst_n = 1'b1;
        mbin = '0;
    endtask

    task automatic test_up_count();
        logic [W-1:0] seq [17];
        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        for (int k = 1; k < 17; k++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
            e = sb.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL up_count_sb[%0d]: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                         o.gray, o.wrap, o.at_max, o.at_min, e.gray, e.wrap, e.at_max, e.at_min);
            end
            n_checks++;
            if (out_gray !== seq[k] || out_wrap !== (k == 16) || out_at_max !== (k == 15)) begin
                n_fail++;
                $display("FAIL up_count_table[%0d]: got gray=%b wrap=%b max=%b want gray=%b wrap=%b max=%b",
                         k, out_gray, out_wrap, out_at_max, seq[k], (k == 16), (k == 15));
            end
        end
    endtask

    task automatic test_down_wrap();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observe();
        n_checks++;
        if (o !== e || out_gray !== 4'b1000 || out_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap: got gray=%b wrap=%b want 1000/1", out_gray, out_wrap);
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observe();
        n_checks++;
        if (o !== e || out_gray !== 4'b1001 || out_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL down_after_wrap: got gray=%b wrap=%b want 1001/0", out_gray, out_wrap);
        end
    endtask

    task automatic test_saturate();
        drive(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1);
        void'(sb.pop_front());
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
            e = sb.pop_front();
            o = observe();
            n_checks++;
            if (o !== e || out_gray !== 4'b1000 || out_wrap !== 1'b0 || out_at_max !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_max[%0d]: got gray=%b wrap=%b max=%b want 1000/0/1",
                         k, out_gray, out_wrap, out_at_max);
            end
        end
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        e = sb.pop_front();
        o = observe();
        n_checks++;
        if (o !== e || out_gray !== 4'b0000 || out_wrap !== 1'b0 || out_at_min !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_min: got gray=%b wrap=%b min=%b want 0000/0/1", out_gray, out_wrap, out_at_min);
        end
    endtask

    task automatic test_load_priority();
        drive(1'b0, 1'b1, 4'b1101, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front();
        o = observe();
        n_checks++;
        if (o !== e || out_gray !== 4'b1101) begin
            n_fail++;
            $display("FAIL load_over_en: got gray=%b want 1101", out_gray);
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front();
        o = observe();
        n_checks++;
        if (o !== e || out_gray !== 4'b1111) begin
            n_fail++;
            $display("FAIL step_after_load: got gray=%b want 1111", out_gray);
        end
        drive(1'b1, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front();
        o = observe();
        n_checks++;
        if (o !== e || out_gray !== 4'b0000 || out_at_min !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_over_load: got gray=%b min=%b want 0000/1", out_gray, out_at_min);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        void'(sb.pop_front());
        repeat (4) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
            void'(sb.pop_front());
        end
        n_checks++;
        if (out_gray !== 4'b0110) begin
            n_fail++;
            $display("FAIL async_precondition: got gray=%b want 0110", out_gray);
        end
        #2 rst_n = 1'b0;
        #1;
        o = observe();
        n_checks++;
        if (o !== exp_t'({4'b0000, 1'b0, 1'b0, 1'b1})) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%b/%b/%b want 0000/0/0/1", o.gray, o.wrap, o.at_max, o.at_min);
        end
        mbin = '0;
        #2 rst_n = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front();
        o = observe();
        n_checks++;
        if (o !== e || out_gray !== 4'b0001) begin
            n_fail++;
            $display("FAIL resume_after_reset: got gray=%b want 0001", out_gray);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] prev;
        for (int k = 0; k < 10000; k++) begin
            prev = out_gray;
            drive(1'b0, 1'b0, '0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_sb_empty: got 0 entries want 1");
            end else begin
                e = sb.pop_front();
                o = observe();
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rand_sb[%0d]: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                             o.gray, o.wrap, o.at_max, o.at_min, e.gray, e.wrap, e.at_max, e.at_min);
                end
            end
            if (stepped) begin
                n_checks++;
                if ($countones(out_gray ^ prev) != 1) begin
                    n_fail++;
                    $display("FAIL rand_onebit[%0d]: got %b -> %b want single-bit change", k, prev, out_gray);
                end
            end
            n_checks++;
            if (g2b(out_gray) !== mbin) begin
                n_fail++;
                $display("FAIL rand_convert[%0d]: got bin=%b want %b", k, g2b(out_gray), mbin);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_saturate();
        test_load_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion want finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
